conversao_bin_bcd: RTL and testbench
====================================

// Module: conversao_bin_bcd
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3 / double dabble), one input bit per clock.
//  Inverse of the team's BCD-to-binary stage: turns a binary count (stopwatch/timer value)
//  into packed BCD digits for the 7-segment display path.
//  Start/busy/done handshake lets the display FSM request a conversion and latch the result.
// PARAMETERS
//  BIN_W   14  width of binary input; 14 covers 0..9999 (BIN_W >= 4)
//  DIGITS  4   number of BCD output digits; output width 4*DIGITS
// PORTS
//  clk        in   1         system clock, all state updates on rising edge
//  rst        in   1         asynchronous, active-high reset
//  start      in   1         conversion request, sampled only in state IDLE
//  bin_in     in   BIN_W     binary value, captured on the accepting edge only
//  busy       out  1         high while state CONV
//  done       out  1         one-cycle pulse, bcd_out/overflow valid
//  bcd_out    out  4*DIGITS  packed BCD, digit 0 in [3:0]; held until next done
//  overflow   out  1         last captured bin_in > 10^DIGITS-1; held until next done
// BEHAVIOUR
//  Interface: one clock (clk); rst asynchronous, active-high.
//  Reset: state=IDLE; busy=0, done=0, bcd_out=0, overflow=0; internal shift/scratch cleared.
//  States: IDLE -> CONV -> FIM -> IDLE.
//   IDLE: start=1 at edge k -> capture bin_in into shift reg, clear BCD scratch,
//         clear bit counter, latch ovf_int = (bin_in > 10^DIGITS-1); go CONV (busy=1 after edge k).
//   CONV: each edge: every scratch digit >= 5 gets +3 (all digits in parallel, each 4-bit),
//         then {scratch,shift} shifted left 1 (shift-reg MSB enters scratch bit 0).
//         Exactly BIN_W such edges: k+1 .. k+BIN_W. On edge k+BIN_W: go FIM,
//         bcd_out <= ovf_int ? all digits 4'h9 : scratch after final shift; overflow <= ovf_int.
//   FIM:  done=1, busy=0 for exactly one cycle; next edge -> IDLE, done=0.
//  Latency: start sampled at edge k -> done high in cycle after edge k+BIN_W (BIN_W+1 edges).
//   Throughput: one conversion per BIN_W+2 cycles (start may be held high continuously).
//  start ignored in CONV and FIM (no queueing); bin_in changes after capture have no effect.
//  Scratch width is 4*DIGITS bits; bits shifted out of the top digit are discarded
//   (only possible on overflow, masked by saturation).
//  bcd_out/overflow update only on the CONV->FIM edge; stable at all other times.
//  busy and done never high together; done never high in IDLE or CONV.
//  rst asserted mid-conversion: immediate return to reset values, no done pulse;
//   first start after rst release starts a fresh conversion.
//  All outputs registered; no combinational path input->output.
// TESTING
//  1 bin_in=0, start pulse at edge k -> done=1 in cycle after edge k+14, bcd_out=16'h0000, overflow=0.
//  2 bin_in=1234 -> bcd_out=16'h1234; bin_in=9999 -> 16'h9999, overflow=0; busy high exactly 14 cycles.
//  3 bin_in=10000 (14'h2710) and 16383 -> bcd_out=16'h9999, overflow=1; next bin_in=5 -> 16'h0005, overflow=0.
//  4 start pulse during CONV with different bin_in -> ignored; result matches first value, single done.
//  5 start held high, bin_in sequence 7, 59, 600 -> three done pulses 16 cycles apart,
//     bcd_out 16'h0007, 16'h0059, 16'h0600.
//  6 rst asserted at cycle 6 of CONV -> busy=0, bcd_out=0 immediately, no done; new start converts correctly.
//  Exhaustive sweep 0..16383 vs reference model; assertions: busy&done never both 1, done width = 1 cycle.

Source files
------------

// File: rtl/conversao_bin_bcd.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Start/busy/done handshake; result saturates to all nines when the input exceeds DIGITS digits.
module conversao_bin_bcd #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  // state | meaning
  // IDLE  | waiting for start, outputs hold last result
  // CONV  | shifting one input bit per clock into the BCD scratch
  // FIM   | one-cycle done pulse, result valid
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIM  = 2'd2
  } state_t;

  localparam int          CNT_W   = $clog2(BIN_W);
  localparam logic [63:0] MAX_BCD = (64'd10 ** DIGITS) - 64'd1;
  localparam int          SW      = 4 * DIGITS;

  state_t             r_state;
  state_t             w_next;
  logic [BIN_W-1:0]   r_sh;
  logic [SW-1:0]      r_scr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_int;
  logic               r_busy;
  logic               r_done;
  logic [SW-1:0]      r_bcd;
  logic               r_ovf;
  logic [SW-2:0]      w_adj;
  logic [SW-1:0]      w_scr_sh;
  logic               w_ovf_in;
  logic               w_last;

  assign w_ovf_in = (64'(bin_in) > MAX_BCD);
  assign w_last   = (r_cnt == '0);

  // The top digit's MSB is shifted out and discarded, so only its low 3 bits are adjusted.
  always_comb begin
    w_adj = '0;
    for (int d = 0; d < DIGITS - 1; d++) begin
      w_adj[4*d +: 4] = (r_scr[4*d +: 4] >= 4'd5) ? r_scr[4*d +: 4] + 4'd3 : r_scr[4*d +: 4];
    end
    w_adj[SW-2 -: 3] = (r_scr[SW-1 -: 4] >= 4'd5) ? r_scr[SW-2 -: 3] + 3'd3 : r_scr[SW-2 -: 3];
  end

  assign w_scr_sh = {w_adj, r_sh[BIN_W-1]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CONV;
      CONV:    if (w_last) w_next = FIM;
      FIM:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == CONV);
      r_done  <= (w_next == FIM);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh      <= '0;
      r_scr     <= '0;
      r_cnt     <= '0;
      r_ovf_int <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_sh      <= bin_in;
        r_scr     <= '0;
        r_cnt     <= CNT_W'(BIN_W - 1);
        r_ovf_int <= w_ovf_in;
      end else if (r_state == CONV) begin
        r_sh  <= {r_sh[BIN_W-2:0], 1'b0};
        r_scr <= w_scr_sh;
        r_cnt <= r_cnt - 1'b1;
        if (w_last) begin
          r_bcd <= r_ovf_int ? {DIGITS{4'h9}} : w_scr_sh;
          r_ovf <= r_ovf_int;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd_out  = r_bcd;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_conversao_bin_bcd.sv
// Bench for conversao_bin_bcd: directed cases plus random values against a decimal-arithmetic model.
module tb_conversao_bin_bcd;

  localparam int BIN_W = 14;

  logic             clk;
  logic             rst;
  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [15:0]      bcd_out;
  logic             overflow;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic prev_done = 1'b0;

  conversao_bin_bcd #(.BIN_W(BIN_W), .DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_and_done", 32'(busy & done), 32'd0);
      chk("done_width", 32'(done & prev_done), 32'd0);
    end
    prev_done <= done;
  end

  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) return 16'h9999;
    return 16'((v % 10) + ((v / 10) % 10) * 16 + ((v / 100) % 10) * 256 + ((v / 1000) % 10) * 4096);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Assumes the DUT is in IDLE; optionally pokes start with a different value mid-conversion.
  task automatic convert(input int v, input bit poke);
    logic [15:0] prev;
    int n;
    int nbusy;
    prev   = bcd_out;
    bin_in = v[BIN_W-1:0];
    start  = 1'b1;
    tick;
    start  = 1'b0;
    bin_in = 14'($urandom);
    n = 0;
    nbusy = 0;
    while (done !== 1'b1 && n < BIN_W + 4) begin
      if (busy === 1'b1) nbusy++;
      if (poke && n == 3) begin
        start  = 1'b1;
        bin_in = ~v[BIN_W-1:0];
      end else begin
        start = 1'b0;
      end
      tick;
      n++;
      if (done !== 1'b1) chk("bcd_hold", 32'(bcd_out), 32'(prev));
    end
    start = 1'b0;
    chk("latency", 32'(n), 32'(BIN_W));
    chk("busy_cycles", 32'(nbusy), 32'(BIN_W));
    chk("bcd_out", 32'(bcd_out), 32'(ref_bcd(v)));
    chk("overflow", 32'(overflow), 32'(v > 9999));
    chk("busy_in_fim", 32'(busy), 32'd0);
    tick;
    chk("done_drop", 32'(done), 32'd0);
    chk("bcd_after", 32'(bcd_out), 32'(ref_bcd(v)));
  endtask

  initial begin
    int last_cyc;
    int vals[3];
    int n;
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    tick;
    tick;
    rst = 1'b0;
    tick;

    convert(0, 0);
    convert(1234, 0);
    convert(9999, 0);
    convert(10000, 0);
    convert(16383, 0);
    convert(5, 0);
    convert(4321, 1);

    // start held high: back-to-back conversions
    vals = '{7, 59, 600};
    bin_in = 14'(vals[0]);
    start  = 1'b1;
    last_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (done !== 1'b1 && n < 40) begin
        tick;
        n++;
      end
      chk("b2b_bcd", 32'(bcd_out), 32'(ref_bcd(vals[i])));
      if (i > 0) chk("b2b_spacing", 32'(cyc - last_cyc), 32'(BIN_W + 2));
      last_cyc = cyc;
      if (i < 2) bin_in = 14'(vals[i+1]);
      else start = 1'b0;
      tick;
    end

    // reset in the middle of a conversion
    bin_in = 14'd1234;
    start  = 1'b1;
    tick;
    start  = 1'b0;
    repeat (6) tick;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_bcd", 32'(bcd_out), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    tick;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (done === 1'b1) n++;
    end
    chk("no_done_after_rst", 32'(n), 32'd0);
    convert(876, 0);

    for (int i = 0; i < 250; i++) begin
      convert(int'($urandom_range(0, 16383)), 1'(i % 17 == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
